// File: rtl/bit_serializer_pkg.sv
// Shared types and default parameter values for the bit serializer.
package bit_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int   DEF_WIDTH      = 8;
    localparam int   DEF_MSB_FIRST  = 0;
    localparam logic DEF_IDLE_LEVEL = 1'b0;

endpackage

// File: rtl/bit_serializer_hold.sv
// One-entry hold register with a full flag, sitting between the upstream
// handshake and the shifter.
module bit_serializer_hold
    import bit_serializer_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             take,
    output logic [WIDTH-1:0] data_out,
    output logic             full
);

    logic [WIDTH-1:0] r_data;
    logic             r_full;

    // load is only ever asserted while empty, so it never races a take
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data <= '0;
            r_full <= 1'b0;
        end else if (load) begin
            r_data <= data_in;
            r_full <= 1'b1;
        end else if (take) begin
            r_full <= 1'b0;
        end
    end

    assign data_out = r_data;
    assign full     = r_full;

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter feeding the downstream Mealy FSM's x input,
// with a one-word hold buffer for gapless back-to-back frames.
//
// state | meaning
// IDLE  | no frame on x; x = IDLE_LEVEL, x_valid = 0
// SHIFT | a frame bit is on x; x_valid = 1
module bit_serializer
    import bit_serializer_pkg::*;
#(
    parameter int   WIDTH      = DEF_WIDTH,
    parameter int   MSB_FIRST  = DEF_MSB_FIRST,
    parameter logic IDLE_LEVEL = DEF_IDLE_LEVEL
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             frame_done,
    output logic             busy
);

    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;
    logic             r_x;
    logic             r_x_valid;
    logic             r_frame_done;

    logic             w_full;
    logic             w_load;
    logic             w_take;
    logic             w_last;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_hold_data;

    function automatic logic first_bit(input logic [WIDTH-1:0] d);
        if (MSB_FIRST != 0) return d[WIDTH-1];
        else                return d[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] d);
        if (MSB_FIRST != 0) return {d[WIDTH-2:0], 1'b0};
        else                return {1'b0, d[WIDTH-1:1]};
    endfunction

    assign in_ready  = rst & ~w_full;
    assign w_load    = in_valid & in_ready;
    assign w_last    = (r_state == SHIFT) && (r_cnt == LAST_IDX);
    assign w_take    = w_full && ((r_state == IDLE) || w_last);
    assign w_cnt_nxt = r_cnt + CW'(1);

    bit_serializer_hold #(
        .WIDTH(WIDTH)
    ) u_hold (
        .clk      (clk),
        .rst      (rst),
        .load     (w_load),
        .data_in  (in_data),
        .take     (w_take),
        .data_out (w_hold_data),
        .full     (w_full)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_shreg      <= '0;
            r_cnt        <= '0;
            r_x          <= IDLE_LEVEL;
            r_x_valid    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_full) begin
                        r_state      <= SHIFT;
                        r_shreg      <= shift_once(w_hold_data);
                        r_x          <= first_bit(w_hold_data);
                        r_x_valid    <= 1'b1;
                        r_cnt        <= '0;
                        r_frame_done <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (w_last) begin
                        r_cnt        <= '0;
                        r_frame_done <= 1'b0;
                        // a held word continues straight on with no idle gap
                        if (w_full) begin
                            r_shreg   <= shift_once(w_hold_data);
                            r_x       <= first_bit(w_hold_data);
                            r_x_valid <= 1'b1;
                        end else begin
                            r_state   <= IDLE;
                            r_x       <= IDLE_LEVEL;
                            r_x_valid <= 1'b0;
                        end
                    end else begin
                        r_cnt        <= w_cnt_nxt;
                        r_shreg      <= shift_once(r_shreg);
                        r_x          <= first_bit(r_shreg);
                        r_frame_done <= (w_cnt_nxt == LAST_IDX);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign x          = r_x;
    assign x_valid    = r_x_valid;
    assign frame_done = r_frame_done;
    assign busy       = (r_state == SHIFT) | w_full;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: LSB-first/idle-0 and MSB-first/idle-1 instances
// share one stimulus stream and are compared against a word-level model.
module tb_bit_serializer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] in_data;
    logic         in_valid;

    logic rdy_l, x_l, xv_l, fd_l, busy_l;
    logic rdy_m, x_m, xv_m, fd_m, busy_m;

    always #5 clk = ~clk;

    bit_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(1'b0)) dut_l (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_l), .x(x_l), .x_valid(xv_l), .frame_done(fd_l), .busy(busy_l)
    );

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1'b1)) dut_m (
        .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
        .in_ready(rdy_m), .x(x_m), .x_valid(xv_m), .frame_done(fd_m), .busy(busy_m)
    );

    // word-level reference: one held word, one word on the wire, bit position
    bit           m_full  = 1'b0;
    bit           m_shift = 1'b0;
    int           m_idx   = 0;
    logic [W-1:0] m_hold  = '0;
    logic [W-1:0] m_cur   = '0;

    logic [W-1:0] src_q[$];
    logic [W-1:0] exp_l[$];
    logic [W-1:0] exp_m[$];
    logic [W-1:0] asm_l = '0;
    logic [W-1:0] asm_m = '0;
    int           nb_l  = 0;
    int           nb_m  = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: got %0h, want %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        bit acc;
        logic ex_l, ex_m;
        in_valid = (src_q.size() > 0);
        in_data  = in_valid ? src_q[0] : W'($urandom);
        acc = rst && in_valid && !m_full;
        @(posedge clk);
        if (!rst) begin
            m_full = 0; m_shift = 0; m_idx = 0;
            exp_l.delete(); exp_m.delete();
            nb_l = 0; nb_m = 0; asm_l = '0; asm_m = '0;
        end else begin
            if (m_shift && m_idx < W - 1) begin
                m_idx++;
            end else if (m_full) begin
                m_cur = m_hold; m_full = 0; m_shift = 1; m_idx = 0;
            end else begin
                m_shift = 0;
            end
            if (acc) begin
                m_hold = in_data; m_full = 1;
                exp_l.push_back(in_data);
                exp_m.push_back(in_data);
                void'(src_q.pop_front());
            end
        end
        #1;
        ex_l = m_shift ? m_cur[m_idx]         : 1'b0;
        ex_m = m_shift ? m_cur[W - 1 - m_idx] : 1'b1;
        chk("ready_l", rdy_l,  rst && !m_full);
        chk("ready_m", rdy_m,  rst && !m_full);
        chk("x_l",     x_l,    ex_l);
        chk("x_m",     x_m,    ex_m);
        chk("xv_l",    xv_l,   m_shift);
        chk("xv_m",    xv_m,   m_shift);
        chk("fd_l",    fd_l,   m_shift && m_idx == W - 1);
        chk("fd_m",    fd_m,   m_shift && m_idx == W - 1);
        chk("busy_l",  busy_l, m_shift || m_full);
        chk("busy_m",  busy_m, m_shift || m_full);
        // rebuild words from the serial streams and match them to accept order
        if (xv_l === 1'b1) begin
            if (nb_l < W) asm_l[nb_l] = x_l;
            nb_l++;
        end
        if (xv_m === 1'b1) begin
            asm_m = {asm_m[W-2:0], x_m};
            nb_m++;
        end
        if (fd_l === 1'b1) begin
            chk("frame_len_l", nb_l, W);
            if (exp_l.size() == 0) begin
                total++; bad++;
                $error("FAIL frame_extra_l: got %0h, want none", asm_l);
            end else chk("frame_word_l", asm_l, exp_l.pop_front());
            nb_l = 0;
        end
        if (fd_m === 1'b1) begin
            chk("frame_len_m", nb_m, W);
            if (exp_m.size() == 0) begin
                total++; bad++;
                $error("FAIL frame_extra_m: got %0h, want none", asm_m);
            end else chk("frame_word_m", asm_m, exp_m.pop_front());
            nb_m = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_idle(input string tag, input int budget);
        bit done = 0;
        for (int i = 0; i < budget; i++) begin
            if (src_q.size() == 0 && busy_l === 1'b0 && busy_m === 1'b0) begin
                done = 1;
                break;
            end
            cycle();
        end
        if (!done) begin
            total++; bad++;
            $error("FAIL %s: still busy after %0d cycles, want idle", tag, budget);
        end
    endtask

    initial begin
        logic lsb_seq[8];
        logic msb_seq[8];
        int   nv;
        int   fd_t[$];
        int   n_rand;
        lsb_seq = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        msb_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

        rst = 1'b0; in_valid = 1'b0; in_data = '0;
        run(3);
        chk("reset_idle_x_m", x_m, 1'b1);
        rst = 1'b1;

        // single word, accepted on the first edge out of reset
        src_q.push_back(8'hB4);
        cycle();
        chk("b4_accepted", src_q.size(), 0);
        for (int k = 0; k < 8; k++) begin
            cycle();
            chk("b4_seq_l", x_l, lsb_seq[k]);
            chk("b4_seq_m", x_m, msb_seq[k]);
            chk("b4_fd_l",  fd_l, (k == 7));
        end
        cycle();
        chk("b4_idle_after", xv_l, 1'b0);

        // back-to-back frames with in_valid held high
        src_q.push_back(8'hFF);
        src_q.push_back(8'h00);
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (xv_l === 1'b1) nv++;
            if (fd_l === 1'b1) fd_t.push_back(k);
        end
        chk("b2b_valid_cycles", nv, 16);
        chk("b2b_fd_count", fd_t.size(), 2);
        if (fd_t.size() == 2) chk("b2b_fd_gap", fd_t[1] - fd_t[0], 8);

        // backpressure: three words queued at once
        src_q.push_back(8'h12);
        src_q.push_back(8'h34);
        src_q.push_back(8'h56);
        wait_idle("backpressure_drain", 60);
        chk("bp_all_emitted", exp_l.size(), 0);

        // reset at bit 3 of A5 while 3C is held
        src_q.push_back(8'hA5);
        src_q.push_back(8'h3C);
        for (int i = 0; i < 20; i++) begin
            if (m_shift && m_idx == 3) break;
            cycle();
        end
        chk("rst_mid_at_bit3", m_idx, 3);
        chk("rst_mid_hold_full", busy_l && !rdy_l, 1'b1);
        src_q.delete();
        rst = 1'b0;
        cycle();
        chk("rst_mid_xv",   xv_l,   1'b0);
        chk("rst_mid_busy", busy_l, 1'b0);
        chk("rst_mid_x_m",  x_m,    1'b1);
        chk("rst_mid_fd",   fd_l,   1'b0);
        rst = 1'b1;
        src_q.push_back(8'h5A);
        wait_idle("post_reset_frame", 30);
        chk("post_reset_emitted", exp_l.size(), 0);

        // random traffic with random gaps
        n_rand = 0;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                src_q.push_back(W'($urandom));
                n_rand++;
            end
            run($urandom_range(0, 12));
        end
        wait_idle("random_drain", 800);
        chk("random_emitted", exp_l.size(), 0);
        chk("random_emitted_m", exp_m.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
